// File: rtl/rtc_pkg.sv
// Shared definitions for the V3023 RTC transfer sequencer: FSM states, bus phases
// and well-known RTC register addresses.
package rtc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_ADDR_XFER = 3'd2,
      ST_DATA_XFER = 3'd3,
      ST_DONE      = 3'd4
   } seq_state_e;

   typedef enum logic [2:0] {
      PH_IDLE   = 3'd0,
      PH_SETUP  = 3'd1,
      PH_STROBE = 3'd2,
      PH_HOLD   = 3'd3,
      PH_GAP    = 3'd4
   } bus_phase_e;

   localparam int unsigned RTC_ADDR_W = 8;

   localparam logic [RTC_ADDR_W-1:0] RTC_SEC          = 8'h21;
   localparam logic [RTC_ADDR_W-1:0] RTC_MIN          = 8'h22;
   localparam logic [RTC_ADDR_W-1:0] RTC_HOUR         = 8'h23;
   localparam logic [RTC_ADDR_W-1:0] RTC_XFER_RAM_CMD = 8'hF1;

endpackage

// File: rtl/rtc_bus_cycle.sv
// One Intel-mode bus cycle: SETUP, STROBE, HOLD (PHASE_CYC clocks each) then a 1-clock GAP.
// A go in the GAP cycle chains the next transfer back-to-back.
module rtc_bus_cycle
   import rtc_pkg::*;
#(
   parameter int unsigned PHASE_CYC = 2
) (
   input  logic Clock,
   input  logic Reset,
   input  logic clr_i,
   input  logic go_i,
   input  logic rd_i,
   output logic cs_n_o,
   output logic wr_n_o,
   output logic rd_n_o,
   output logic last_strobe_o,
   output logic done_o
);

   localparam int unsigned CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYC - 1);

   bus_phase_e       phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rd_q, rd_d;
   logic             cs_n_q, cs_n_d;
   logic             wr_n_q, wr_n_d;
   logic             rd_n_q, rd_n_d;
   logic             last_q, last_d;
   logic             done_q, done_d;
   logic             phase_end_c;

   always_comb begin
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      phase_end_c = (cnt_q == CNT_LAST);

      case (phase_q)
         PH_SETUP: begin
            phase_d = phase_end_c ? PH_STROBE : PH_SETUP;
            cnt_d   = phase_end_c ? '0 : cnt_q + CNT_W'(1);
         end
         PH_STROBE: begin
            phase_d = phase_end_c ? PH_HOLD : PH_STROBE;
            cnt_d   = phase_end_c ? '0 : cnt_q + CNT_W'(1);
         end
         PH_HOLD: begin
            phase_d = phase_end_c ? PH_GAP : PH_HOLD;
            cnt_d   = phase_end_c ? '0 : cnt_q + CNT_W'(1);
         end
         default: phase_d = PH_IDLE;
      endcase

      if (go_i) begin
         phase_d = PH_SETUP;
         cnt_d   = '0;
         rd_d    = rd_i;
      end

      if (clr_i) begin
         phase_d = PH_IDLE;
         cnt_d   = '0;
         rd_d    = 1'b0;
      end

      // Outputs are decoded from the next phase so they are registered yet phase-aligned
      cs_n_d = !((phase_d == PH_SETUP) || (phase_d == PH_STROBE) || (phase_d == PH_HOLD));
      wr_n_d = !((phase_d == PH_STROBE) && !rd_d);
      rd_n_d = !((phase_d == PH_STROBE) && rd_d);
      last_d = (phase_d == PH_STROBE) && (cnt_d == CNT_LAST) && rd_d;
      done_d = (phase_d == PH_GAP);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         phase_q <= PH_IDLE;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         cs_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         rd_n_q  <= 1'b1;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         cs_n_q  <= cs_n_d;
         wr_n_q  <= wr_n_d;
         rd_n_q  <= rd_n_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign cs_n_o        = cs_n_q;
   assign wr_n_o        = wr_n_q;
   assign rd_n_o        = rd_n_q;
   assign last_strobe_o = last_q;
   assign done_o        = done_q;

endmodule

// File: rtl/rtc_xfer_sequencer.sv
// Table-driven V3023 RTC transfer sequencer: per step an address write followed by a
// bank write, command write or bank read, using one shared bus-cycle generator.
module rtc_xfer_sequencer
   import rtc_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned REG_W     = 4,
   parameter int unsigned NUM_STEPS = 8,
   parameter int unsigned IDX_W     = 3,
   parameter int unsigned PHASE_CYC = 2
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Mode,
   input  logic [IDX_W:0]    NumSteps,
   input  logic              Abort,
   output logic [IDX_W-1:0]  StepIdx,
   input  logic [ADDR_W-1:0] StepAddr,
   input  logic [REG_W-1:0]  StepBank,
   input  logic              StepCmd,
   output logic [ADDR_W-1:0] Direccion,
   output logic [REG_W-1:0]  AddReg,
   output logic              AD,
   output logic              CS_n,
   output logic              WR_n,
   output logic              RD_n,
   output logic              SD,
   output logic              Cmd,
   output logic              RdLatch,
   output logic              Busy,
   output logic              Ready
);

   localparam logic [IDX_W:0] MAX_STEPS = (IDX_W + 1)'(NUM_STEPS);

   seq_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W:0]    num_q, num_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [REG_W-1:0]  bank_q, bank_d;
   logic              cmd_q, cmd_d;
   logic [ADDR_W-1:0] dir_q, dir_d;
   logic [REG_W-1:0]  add_reg_q, add_reg_d;
   logic              ad_q, ad_d;
   logic              sd_q, sd_d;
   logic              cmd_out_q, cmd_out_d;
   logic              busy_q, busy_d;
   logic              ready_q, ready_d;

   logic              go_c, rd_c, abort_c, bus_done_c;
   logic [IDX_W:0]    clamp_c;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      num_d   = num_q;
      mode_d  = mode_q;
      addr_d  = addr_q;
      bank_d  = bank_q;
      cmd_d   = cmd_q;
      go_c    = 1'b0;
      abort_c = Abort && (state_q != ST_IDLE);
      clamp_c = (NumSteps > MAX_STEPS) ? MAX_STEPS : NumSteps;
      rd_c    = (state_q == ST_ADDR_XFER) && mode_q && !cmd_q;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               mode_d  = Mode;
               num_d   = clamp_c;
               idx_d   = '0;
               state_d = (clamp_c == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            addr_d  = StepAddr;
            bank_d  = StepBank;
            cmd_d   = StepCmd;
            go_c    = 1'b1;
            state_d = ST_ADDR_XFER;
         end
         ST_ADDR_XFER: begin
            if (bus_done_c) begin
               go_c    = 1'b1;
               state_d = ST_DATA_XFER;
            end
         end
         ST_DATA_XFER: begin
            // Index saturates at the last executed step instead of wrapping
            if (bus_done_c) begin
               if (((IDX_W + 1)'(idx_q) + (IDX_W + 1)'(1)) < num_q) begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort_c) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         go_c    = 1'b0;
      end

      dir_d     = (state_d == ST_ADDR_XFER) ? addr_d : '0;
      add_reg_d = (state_d == ST_DATA_XFER) ? bank_d : '0;
      ad_d      = (state_d == ST_DATA_XFER);
      sd_d      = (state_d == ST_ADDR_XFER) ||
                  ((state_d == ST_DATA_XFER) && !(mode_d && !cmd_d));
      cmd_out_d = (state_d == ST_DATA_XFER) && cmd_d;
      busy_d    = (state_d != ST_IDLE);
      ready_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         num_q     <= '0;
         mode_q    <= 1'b0;
         addr_q    <= '0;
         bank_q    <= '0;
         cmd_q     <= 1'b0;
         dir_q     <= '0;
         add_reg_q <= '0;
         ad_q      <= 1'b0;
         sd_q      <= 1'b0;
         cmd_out_q <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         num_q     <= num_d;
         mode_q    <= mode_d;
         addr_q    <= addr_d;
         bank_q    <= bank_d;
         cmd_q     <= cmd_d;
         dir_q     <= dir_d;
         add_reg_q <= add_reg_d;
         ad_q      <= ad_d;
         sd_q      <= sd_d;
         cmd_out_q <= cmd_out_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
      end
   end

   rtc_bus_cycle #(
      .PHASE_CYC(PHASE_CYC)
   ) u_bus (
      .Clock        (Clock),
      .Reset        (Reset),
      .clr_i        (abort_c),
      .go_i         (go_c),
      .rd_i         (rd_c),
      .cs_n_o       (CS_n),
      .wr_n_o       (WR_n),
      .rd_n_o       (RD_n),
      .last_strobe_o(RdLatch),
      .done_o       (bus_done_c)
   );

   assign StepIdx   = idx_q;
   assign Direccion = dir_q;
   assign AddReg    = add_reg_q;
   assign AD        = ad_q;
   assign SD        = sd_q;
   assign Cmd       = cmd_out_q;
   assign Busy      = busy_q;
   assign Ready     = ready_q;

endmodule

// File: doc/rtc_xfer_sequencer.md
Name: rtc_xfer_sequencer

Overview:
Table-driven, parametrised transfer sequencer for the V3023 RTC parallel bus in Intel mode. Each step sends an address transfer followed by a data transfer. The data transfer is one of:
- write from a register-bank entry,
- command write,
- read into a register-bank entry.

It generates all bus timing internally and handles the init, time-set and time-read sequences of the clock controller. Step contents come from an external step table addressed by StepIdx.

Parameters:
ADDR_W, 8, width of RTC address/command byte (Direccion)
REG_W, 4, width of register-bank index (AddReg)
NUM_STEPS, 8, maximum steps per sequence
IDX_W, 3, width of StepIdx/NumSteps (>= clog2(NUM_STEPS))
PHASE_CYC, 2, clocks per bus phase (SETUP, STROBE, HOLD); must be >= 1

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high
Start  in  1  start sequence; sampled only in IDLE
Mode  in  1  0 = write sequence, 1 = read sequence; latched with Start
NumSteps  in  IDX_W+1  number of steps; latched with Start; values > NUM_STEPS clamp to NUM_STEPS
Abort  in  1  cancel sequence
StepIdx  out  IDX_W  index of the step being fetched
StepAddr  in  ADDR_W  table: RTC address for StepIdx
StepBank  in  REG_W  table: bank entry for StepIdx
StepCmd  in  1  table: 1 = data transfer is a command write
Direccion  out  ADDR_W  latched step address; 0 outside ADDR_XFER
AddReg  out  REG_W  latched bank index; 0 outside DATA_XFER
AD  out  1  0 = address transfer, 1 = data transfer
CS_n, WR_n, RD_n  out  1 each  active-low bus strobes
SD  out  1  bus drive enable
Cmd  out  1  data comes from the command source instead of the bank
RdLatch  out  1  one-cycle strobe: capture bus into bank[AddReg]
Busy  out  1  sequence in progress
Ready  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous) values:
  - CS_n=WR_n=RD_n=1.
  - AD, SD, Cmd, RdLatch, Ready, Busy, StepIdx, Direccion, AddReg all 0.
  - FSM goes to IDLE and the bus-cycle generator to its idle phase, including mid-transfer.
- Main FSM: IDLE -> FETCH -> ADDR_XFER -> DATA_XFER -> (FETCH | DONE) -> IDLE.
- IDLE:
  - Start=1 latches Mode and NumSteps (clamped) and sets StepIdx=0.
  - Next state is FETCH, or DONE directly if the clamped NumSteps=0.
- FETCH: 1 cycle. StepAddr/StepBank/StepCmd are registered at the end of the cycle, so the table may change afterwards.
- Every transfer (ADDR_XFER or DATA_XFER) is 3*PHASE_CYC+1 cycles:
  - SETUP: PHASE_CYC cycles, CS_n=0, strobes high.
  - STROBE: PHASE_CYC cycles, CS_n=0, WR_n=0 or RD_n=0.
  - HOLD: PHASE_CYC cycles, CS_n=0, strobes high.
  - GAP: 1 cycle, CS_n=1.
- ADDR_XFER: AD=0, WR strobe, SD=1, Direccion=latched address.
- DATA_XFER: AD=1, AddReg=latched bank index, and:
  - StepCmd=1: WR strobe, SD=1, Cmd=1, in both modes.
  - Mode=0: WR strobe, SD=1, Cmd=0.
  - Mode=1 and StepCmd=0: RD strobe, SD=0, RdLatch=1 in the last STROBE cycle only.
- After DATA_XFER: StepIdx increments, then FETCH if StepIdx < NumSteps, else DONE.
- DONE: 1 cycle with Ready=1, then IDLE.
- Busy=1 in every state except IDLE.
- Latency: Ready is high NumSteps*(6*PHASE_CYC+3) cycles after the edge that samples Start. For PHASE_CYC=2, N=4 this is 60 cycles.
- Start while Busy is ignored.
- Start and Reset asserted together: Reset wins.
- Abort=1 in any non-IDLE state:
  - next cycle the FSM is IDLE with all outputs at reset values;
  - Ready is not pulsed.
- Abort and Start asserted together in IDLE: Start wins; Abort has no effect in IDLE.
- StepIdx wraps never; it holds its last value in IDLE until the next Start.

Decomposition:
- Shared package rtc_pkg:
  - FSM state encodings (IDLE, FETCH, ADDR_XFER, DATA_XFER, DONE);
  - bus phase encodings (SETUP, STROBE, HOLD, GAP);
  - RTC address constants: SEC=8'h21, MIN=8'h22, HOUR=8'h23, XFER_RAM_CMD=8'hF1.
- One sub-module: rtc_bus_cycle. Inputs go, rd, PHASE_CYC. Outputs CS_n, WR_n, RD_n, last_strobe, done (pulse in the GAP cycle). Instantiated once and reused for both transfers.

Test Plan:
1. Mode=0, NumSteps=4, table {21,0,0},{22,1,0},{23,2,0},{F1,0,1}, PHASE_CYC=2 -> Direccion sequence 21,22,23,F1 and AddReg 0,1,2,0; Cmd=1 only in step 3 DATA_XFER; exactly 8 WR_n pulses of 2 cycles each; Ready pulse at cycle 60; RD_n stays 1.
2. Mode=1, NumSteps=3, same first 3 entries -> 3 WR_n pulses (AD=0) and 3 RD_n pulses (AD=1); SD=0 during reads; RdLatch pulses with AddReg=0,1,2; Ready at cycle 45.
3. NumSteps=0 -> Ready at the first cycle after Start, no CS_n activity. NumSteps=15 with NUM_STEPS=8 -> 8 steps executed.
4. Abort during the STROBE phase of step 1 DATA_XFER -> next cycle CS_n=WR_n=1, Busy=0; no Ready ever. A following Start runs the full sequence from StepIdx 0.
5. Reset during step 2 ADDR_XFER -> next cycle all outputs at reset values. Start pulsed while Busy -> no restart, and the Ready timing of the running sequence is unchanged.
6. PHASE_CYC=1, Mode=0, NumSteps=2 -> each transfer is 4 cycles (CS_n low 3 cycles, WR_n low 1 cycle); Ready at cycle 18.
